// File: rtl/led_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler, the visualizer and the LED driver.
// vis_start/drv_start are one-cycle request pulses. vis_dv is a one-cycle completion strobe.
// drv_done is a level that is high whenever the driver is idle.
interface led_frame_scheduler_if;
  logic vis_start;
  logic vis_dv;
  logic drv_start;
  logic drv_done;

  modport master (
    output vis_start,
    output drv_start,
    input  vis_dv,
    input  drv_done
  );

  modport slave (
    input  vis_start,
    input  drv_start,
    output vis_dv,
    output drv_done
  );
endinterface

// File: rtl/led_frame_scheduler.sv
// Frame sequencer: timer/trigger -> visualizer -> LED driver -> WS2801 latch gap.
// Define LED_FRAME_STATS_EN to build the frame/overrun statistics counters.
module led_frame_scheduler #(
  parameter int FRAME_CYCLES   = 208333,
  parameter int LATCH_CYCLES   = 6250,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        trigger,
  input  logic                        clr_err,
  led_frame_scheduler_if.master       hs,
  output logic                        busy,
  output logic                        frame_tick,
  output logic                        overrun,
  output logic                        timeout_err,
  output logic [15:0]                 frame_count,
  output logic [7:0]                  overrun_count,
  output logic [2:0]                  dbg_state
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_VIS_START = 3'd1;
  localparam logic [2:0] S_VIS_WAIT  = 3'd2;
  localparam logic [2:0] S_DRV_START = 3'd3;
  localparam logic [2:0] S_DRV_ARM   = 3'd4;
  localparam logic [2:0] S_DRV_WAIT  = 3'd5;
  localparam logic [2:0] S_LATCH     = 3'd6;

  logic [FW-1:0] tmr_q, tmr_d;
  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    arm_q, arm_d;
  logic [LW-1:0] latch_q, latch_d;
  logic          busy_q, vis_start_q, drv_start_q;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          request;
  logic          overrun_set;
  logic          timeout_set;

  // Free-running frame timer; held at zero while disabled.
  always_comb begin
    tmr_d = '0;
    if (enable && (tmr_q != FRAME_LAST)) tmr_d = tmr_q + 1'b1;
  end

  assign frame_tick  = enable && (tmr_q == FRAME_LAST);
  assign request     = frame_tick || trigger;
  assign overrun_set = frame_tick && (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    case (state_q)
      S_IDLE:      if (request) state_d = S_VIS_START;
      S_VIS_START: state_d = S_VIS_WAIT;
      S_VIS_WAIT: begin
        if (hs.vis_dv) begin
          state_d = S_DRV_START;
        end else if (wait_q == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_d     = S_LATCH;
        end
      end
      S_DRV_START: state_d = S_DRV_ARM;
      // A driver that finishes before we can see done drop still gets a DRV_WAIT pass.
      S_DRV_ARM:   if (!hs.drv_done || (arm_q == 2'd3)) state_d = S_DRV_WAIT;
      S_DRV_WAIT: begin
        if (hs.drv_done) begin
          state_d = S_LATCH;
        end else if (wait_q == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_d     = S_LATCH;
        end
      end
      S_LATCH:     if (latch_q == LATCH_LAST) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Per-state counters restart from zero on every state entry.
  always_comb begin
    wait_d  = '0;
    arm_d   = '0;
    latch_d = '0;
    if (state_d == state_q) begin
      case (state_q)
        S_VIS_WAIT, S_DRV_WAIT: wait_d  = wait_q + 1'b1;
        S_DRV_ARM:              arm_d   = arm_q + 1'b1;
        S_LATCH:                latch_d = latch_q + 1'b1;
        default:                ;
      endcase
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    if (clr_err) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (overrun_set) overrun_d = 1'b1;
    if (timeout_set) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q       <= '0;
      state_q     <= S_IDLE;
      wait_q      <= '0;
      arm_q       <= '0;
      latch_q     <= '0;
      busy_q      <= 1'b0;
      vis_start_q <= 1'b0;
      drv_start_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      tmr_q       <= tmr_d;
      state_q     <= state_d;
      wait_q      <= wait_d;
      arm_q       <= arm_d;
      latch_q     <= latch_d;
      busy_q      <= (state_d != S_IDLE);
      vis_start_q <= (state_d == S_VIS_START);
      drv_start_q <= (state_d == S_DRV_START);
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy         = busy_q;
  assign hs.vis_start = vis_start_q;
  assign hs.drv_start = drv_start_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;
  assign dbg_state    = state_q;

`ifdef LED_FRAME_STATS_EN
  logic        aborted_q, aborted_d;
  logic        frame_done;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  overrun_count_q, overrun_count_d;

  // A frame that ended through a timeout still passes LATCH but does not count.
  assign frame_done = (state_q == S_LATCH) && (latch_q == LATCH_LAST) && !aborted_q;

  always_comb begin
    aborted_d = aborted_q;
    if (state_d == S_VIS_START) aborted_d = 1'b0;
    if (timeout_set)            aborted_d = 1'b1;

    frame_count_d   = clr_err ? 16'd0 : frame_count_q;
    overrun_count_d = clr_err ? 8'd0  : overrun_count_q;
    if (frame_done) frame_count_d = frame_count_d + 16'd1;
    if (overrun_set && (overrun_count_d != 8'hFF)) overrun_count_d = overrun_count_d + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted_q       <= 1'b0;
      frame_count_q   <= '0;
      overrun_count_q <= '0;
    end else begin
      aborted_q       <= aborted_d;
      frame_count_q   <= frame_count_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign frame_count   = frame_count_q;
  assign overrun_count = overrun_count_q;
`else
  assign frame_count   = '0;
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with FRAME=100, LATCH=10, TIMEOUT=50.
// Cycle n is the interval after the n-th rising edge following reset release.
module tb_led_frame_scheduler;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_VIS_WAIT = 3'd2;
  localparam logic [2:0] ST_DRV_ARM  = 3'd4;
  localparam logic [2:0] ST_DRV_WAIT = 3'd5;
  localparam logic [2:0] ST_LATCH    = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        clr_err = 1'b0;
  logic        busy, frame_tick, overrun, timeout_err;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
  logic [2:0]  dbg_state;

  led_frame_scheduler_if hs ();

  led_frame_scheduler #(
    .FRAME_CYCLES   (100),
    .LATCH_CYCLES   (10),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .trigger       (trigger),
    .clr_err       (clr_err),
    .hs            (hs),
    .busy          (busy),
    .frame_tick    (frame_tick),
    .overrun       (overrun),
    .timeout_err   (timeout_err),
    .frame_count   (frame_count),
    .overrun_count (overrun_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- peripheral responders ----------------
  int dv_delay      = 5;
  int drv_low_delay = 2;
  int drv_low_len   = 20;
  int vis_pend      = 0;
  int drv_t         = 0;
  bit drv_active    = 1'b0;

  initial begin
    hs.vis_dv   = 1'b0;
    hs.drv_done = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      vis_pend    = 0;
      drv_active  = 1'b0;
      hs.vis_dv   = 1'b0;
      hs.drv_done = 1'b1;
    end else begin
      hs.vis_dv = 1'b0;
      if (vis_pend > 0) begin
        vis_pend--;
        if (vis_pend == 0) hs.vis_dv = 1'b1;
      end
      if (hs.vis_start && dv_delay > 0) vis_pend = dv_delay;
      if (hs.drv_start) begin
        drv_active = 1'b1;
        drv_t      = 0;
      end else if (drv_active) begin
        drv_t++;
      end
      hs.drv_done = !(drv_active && drv_t >= drv_low_delay && drv_t < drv_low_delay + drv_low_len);
    end
  end

  // ---------------- event monitors ----------------
  logic [31:0] vs_q[$];
  logic [31:0] ds_q[$];
  logic [31:0] tick_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (hs.vis_start) vs_q.push_back(cyc);
      if (hs.drv_start) ds_q.push_back(cyc);
      if (frame_tick)   tick_q.push_back(cyc);
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef LED_FRAME_STATS_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] q_item(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic compare_vis_starts(input string tag);
    check_eq({tag, "_vis_n"}, vs_q.size(), exp_q.size());
    foreach (exp_q[i]) check_eq({tag, "_vis_cyc"}, q_item(vs_q, i), exp_q[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic go_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic en);
    rst           = 1'b1;
    enable        = 1'b0;
    trigger       = 1'b0;
    clr_err       = 1'b0;
    dv_delay      = 5;
    drv_low_delay = 2;
    drv_low_len   = 20;
    vs_q.delete();
    ds_q.delete();
    tick_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = en;
  endtask

  task automatic pulse_trigger(input int n);
    go_cyc(n);
    trigger = 1'b1;
    go_cyc(n + 1);
    trigger = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  int n_vs, n_ds;

  initial begin
    // 1: free-running frames at the nominal rate
    do_reset(1'b1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_vis_start", hs.vis_start, 0);
    check_eq("rst_drv_start", hs.drv_start, 0);
    check_eq("rst_tick", frame_tick, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_frame_count", frame_count, 0);
    check_eq("rst_overrun_count", overrun_count, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    go_cyc(390);
    exp_q = '{32'd100, 32'd200, 32'd300};
    compare_vis_starts("t1");
    check_eq("t1_tick0", q_item(tick_q, 0), 99);
    check_eq("t1_drv_start0", q_item(ds_q, 0), 106);
    go_cyc(400);
    check_eq("t1_tick3", q_item(tick_q, 3), 399);
    check_eq("t1_overrun", overrun, 0);
    check_eq("t1_frame_count", frame_count, stat_exp(3));

    // 2: long frame overlaps the next tick
    do_reset(1'b1);
    dv_delay    = 45;
    drv_low_len = 45;
    go_cyc(198);
    check_eq("t2_overrun_pre", overrun, 0);
    go_cyc(200);
    check_eq("t2_overrun_set", overrun, 1);
    check_eq("t2_overrun_count", overrun_count, stat_exp(1));
    go_cyc(203);
    check_eq("t2_busy_latch", busy, 1);
    go_cyc(204);
    check_eq("t2_busy_idle", busy, 0);
    go_cyc(310);
    exp_q = '{32'd100, 32'd300};
    compare_vis_starts("t2");
    check_eq("t2_drv_start0", q_item(ds_q, 0), 146);
    check_eq("t2_timeout", timeout_err, 0);

    // 3: visualizer never answers
    do_reset(1'b1);
    dv_delay = 0;
    go_cyc(150);
    check_eq("t3_timeout_pre", timeout_err, 0);
    check_eq("t3_state_vis_wait", dbg_state, ST_VIS_WAIT);
    go_cyc(151);
    check_eq("t3_timeout_set", timeout_err, 1);
    check_eq("t3_state_latch", dbg_state, ST_LATCH);
    go_cyc(160);
    check_eq("t3_busy_latch", busy, 1);
    go_cyc(161);
    check_eq("t3_busy_idle", busy, 0);
    check_eq("t3_no_drv_start", ds_q.size(), 0);
    go_cyc(165);
    clr_err = 1'b1;
    go_cyc(166);
    clr_err = 1'b0;
    check_eq("t3_timeout_clr", timeout_err, 0);
    go_cyc(250);
    clr_err = 1'b1;
    go_cyc(251);
    clr_err = 1'b0;
    check_eq("t3_set_beats_clr", timeout_err, 1);
    check_eq("t3_frame_count", frame_count, stat_exp(0));

    // 4: external triggers
    do_reset(1'b0);
    pulse_trigger(7);
    check_eq("t4_vis_start_lat", hs.vis_start, 1);
    pulse_trigger(10);
    go_cyc(50);
    enable = 1'b1;
    pulse_trigger(149);
    go_cyc(160);
    exp_q = '{32'd8, 32'd150};
    compare_vis_starts("t4");
    check_eq("t4_tick", q_item(tick_q, 0), 149);
    check_eq("t4_overrun", overrun, 0);
    check_eq("t4_frame_count", frame_count, stat_exp(1));

    // 5: driver finishes before done is seen low
    do_reset(1'b0);
    drv_low_len = 0;
    pulse_trigger(5);
    go_cyc(13);
    check_eq("t5_arm_enter", dbg_state, ST_DRV_ARM);
    go_cyc(16);
    check_eq("t5_arm_last", dbg_state, ST_DRV_ARM);
    go_cyc(17);
    check_eq("t5_drv_wait", dbg_state, ST_DRV_WAIT);
    go_cyc(18);
    check_eq("t5_latch", dbg_state, ST_LATCH);
    go_cyc(27);
    check_eq("t5_busy_latch", busy, 1);
    go_cyc(28);
    check_eq("t5_busy_idle", busy, 0);
    check_eq("t5_frame_count", frame_count, stat_exp(1));
    check_eq("t5_timeout", timeout_err, 0);

    // 6: asynchronous reset mid-frame
    do_reset(1'b0);
    pulse_trigger(5);
    go_cyc(20);
    check_eq("t6_drv_wait", dbg_state, ST_DRV_WAIT);
    rst = 1'b1;
    #1;
    check_eq("t6_async_busy", busy, 0);
    check_eq("t6_async_state", dbg_state, ST_IDLE);
    check_eq("t6_async_vis_start", hs.vis_start, 0);
    check_eq("t6_async_drv_start", hs.drv_start, 0);
    n_vs = vs_q.size();
    n_ds = ds_q.size();
    @(posedge clk);
    #1;
    rst = 1'b0;
    go_cyc(30);
    check_eq("t6_no_vis_start", vs_q.size(), n_vs);
    check_eq("t6_no_drv_start", ds_q.size(), n_ds);
    check_eq("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
